// File: rtl/configs_pkg.sv
// rtl/configs_pkg.sv - shared types and helpers for the config loader
package configs_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   localparam logic SEQ  = 1'b0;
   localparam logic ADDR = 1'b1;

   function automatic int cfg_w(input int word_w, input int num_words);
      return word_w * num_words;
   endfunction

endpackage

// File: rtl/configs_shadow_ram.sv
// rtl/configs_shadow_ram.sv - flop-array shadow store with registered readback
module configs_shadow_ram
   import configs_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int NUM_WORDS = 37,
   localparam int ADDR_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
   localparam int IMG_W = cfg_w(WORD_W, NUM_WORDS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata,
   output logic [IMG_W-1:0]  flat
);

   localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(NUM_WORDS);

   logic [WORD_W-1:0] mem [NUM_WORDS];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
         rdata <= '0;
      end else begin
         if (we && ({1'b0, waddr} < FULL)) mem[waddr] <= wdata;
         // Reads see the pre-write contents of the same edge.
         rdata <= ({1'b0, raddr} < FULL) ? mem[raddr] : '0;
      end
   end

   for (genvar g = 0; g < NUM_WORDS; g++) begin : g_flat
      assign flat[g*WORD_W +: WORD_W] = mem[g];
   end

endmodule

// File: rtl/configs_loader.sv
// rtl/configs_loader.sv - streams config words into a shadow and commits them atomically
module configs_loader
   import configs_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int NUM_WORDS = 37,
   localparam int ADDR_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
   localparam int IMG_W = cfg_w(WORD_W, NUM_WORDS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_start,
   input  logic              io_mode,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [WORD_W-1:0] io_d_in,
   input  logic              io_d_valid,
   output logic              io_d_ready,
   output logic              io_busy,
   output logic              io_done,
   output logic              io_err,
   output logic [ADDR_W:0]   io_word_cnt,
   input  logic [ADDR_W-1:0] io_rd_addr,
   output logic [WORD_W-1:0] io_rd_data,
   output logic [IMG_W-1:0]  io_configs_out
);

   localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(NUM_WORDS);

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic              accept;
   logic              in_range;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W:0]   cnt_inc;
   logic [IMG_W-1:0]  shadow_flat;
   logic [IMG_W-1:0]  commit_img;

   assign accept   = io_d_valid & io_d_ready;
   assign in_range = (io_mode == SEQ) || ({1'b0, io_addr} < FULL);
   assign waddr    = (io_mode == SEQ) ? ptr : io_addr;
   assign we       = accept & in_range;
   assign cnt_inc  = io_word_cnt + (ADDR_W + 1)'(1);

   // The final word lands in the shadow on the commit edge, so merge it in here.
   always_comb begin
      commit_img = shadow_flat;
      for (int i = 0; i < NUM_WORDS; i++) begin
         if (we && (waddr == ADDR_W'(i))) commit_img[WORD_W*i +: WORD_W] = io_d_in;
      end
   end

   configs_shadow_ram #(
      .WORD_W    (WORD_W),
      .NUM_WORDS (NUM_WORDS)
   ) u_shadow (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .waddr (waddr),
      .wdata (io_d_in),
      .raddr (io_rd_addr),
      .rdata (io_rd_data),
      .flat  (shadow_flat)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         io_d_ready     <= 1'b0;
         io_busy        <= 1'b0;
         io_done        <= 1'b0;
         io_err         <= 1'b0;
         io_word_cnt    <= '0;
         ptr            <= '0;
         io_configs_out <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (io_start) begin
                  state       <= LOAD;
                  io_d_ready  <= 1'b1;
                  io_busy     <= 1'b1;
                  io_done     <= 1'b0;
                  io_err      <= 1'b0;
                  io_word_cnt <= '0;
                  ptr         <= '0;
               end
            end
            LOAD: begin
               if (accept) begin
                  if (in_range) begin
                     io_word_cnt <= cnt_inc;
                     if (io_mode == SEQ) ptr <= ptr + ADDR_W'(1);
                     if (cnt_inc == FULL) begin
                        state          <= DONE;
                        io_d_ready     <= 1'b0;
                        io_busy        <= 1'b0;
                        io_done        <= 1'b1;
                        io_configs_out <= commit_img;
                     end
                  end else begin
                     io_err <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_configs_loader.sv
// tb/tb_configs_loader.sv - randomized scoreboard bench for configs_loader
module tb_configs_loader;

   localparam int W  = 32;
   localparam int N  = 37;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          io_start;
   logic          io_mode;
   logic [AW-1:0] io_addr;
   logic [W-1:0]  io_d_in;
   logic          io_d_valid;
   logic          io_d_ready;
   logic          io_busy;
   logic          io_done;
   logic          io_err;
   logic [AW:0]   io_word_cnt;
   logic [AW-1:0] io_rd_addr;
   logic [W-1:0]  io_rd_data;
   logic [W*N-1:0] io_configs_out;

   always #5 clk = ~clk;

   configs_loader #(.WORD_W(W), .NUM_WORDS(N)) dut (
      .clk            (clk),
      .reset          (reset),
      .io_start       (io_start),
      .io_mode        (io_mode),
      .io_addr        (io_addr),
      .io_d_in        (io_d_in),
      .io_d_valid     (io_d_valid),
      .io_d_ready     (io_d_ready),
      .io_busy        (io_busy),
      .io_done        (io_done),
      .io_err         (io_err),
      .io_word_cnt    (io_word_cnt),
      .io_rd_addr     (io_rd_addr),
      .io_rd_data     (io_rd_data),
      .io_configs_out (io_configs_out)
   );

   typedef struct {
      logic           ready, busy, done, err;
      logic [AW:0]    cnt;
      logic [W*N-1:0] img;
      logic [W-1:0]   rd_exp;
   } rec_t;

   rec_t exp_q[$];
   rec_t mr;
   int   checks = 0;
   int   errors = 0;

   // Reference model: what the loader should hold after the coming edge.
   logic [W-1:0] m_sh  [N];
   logic [W-1:0] m_act [N];
   bit           m_load, m_done, m_err;
   int           m_cnt, m_ptr;
   int           force_rd = -1;

   function automatic logic [W*N-1:0] pack_act();
      logic [W*N-1:0] v;
      for (int i = 0; i < N; i++) v[W*i +: W] = m_act[i];
      return v;
   endfunction

   task automatic cyc(input bit st, input bit v, input bit m, input int a, input logic [W-1:0] d);
      rec_t r;
      int   ra;
      io_start   = st;
      io_d_valid = v;
      io_mode    = m;
      io_addr    = AW'(a);
      io_d_in    = d;
      ra         = (force_rd >= 0) ? force_rd : int'($urandom_range(0, 39));
      io_rd_addr = AW'(ra);
      r.rd_exp   = (ra < N) ? m_sh[ra] : '0;
      if (!m_load) begin
         if (st) begin
            m_load = 1; m_done = 0; m_err = 0; m_cnt = 0; m_ptr = 0;
         end
      end else if (v) begin
         if (!m) begin
            m_sh[m_ptr] = d; m_ptr++; m_cnt++;
         end else if (a < N) begin
            m_sh[a] = d; m_cnt++;
         end else begin
            m_err = 1;
         end
         if (m_cnt == N) begin
            m_load = 0; m_done = 1;
            for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
         end
      end
      r.ready = m_load; r.busy = m_load; r.done = m_done; r.err = m_err;
      r.cnt = (AW + 1)'(m_cnt);
      r.img = pack_act();
      exp_q.push_back(r);
      @(negedge clk);
   endtask

   task automatic rst_cyc();
      rec_t r;
      reset = 1'b0; io_start = 1'b0; io_d_valid = 1'b0;
      io_rd_addr = AW'($urandom_range(0, 39));
      for (int i = 0; i < N; i++) begin m_sh[i] = '0; m_act[i] = '0; end
      m_load = 0; m_done = 0; m_err = 0; m_cnt = 0; m_ptr = 0;
      r.ready = 0; r.busy = 0; r.done = 0; r.err = 0; r.cnt = '0;
      r.img = '0; r.rd_exp = '0;
      exp_q.push_back(r);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic seq_words(input logic [W-1:0] base, input int first, input int count, input bit gaps);
      int i = first;
      while (i < first + count) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            cyc(($urandom_range(0, 3) == 0), 0, 0, 0, $urandom);
         end else begin
            cyc(gaps && ($urandom_range(0, 7) == 0), 1, 0, 0, base + W'(i));
            i++;
         end
      end
   endtask

   // Monitor: one expectation record per edge, compared just after it.
   always @(posedge clk) begin
      #2;
      if (exp_q.size() > 0) begin
         mr = exp_q.pop_front();
         checks++;
         if ({io_d_ready, io_busy, io_done, io_err, io_word_cnt} !== {mr.ready, mr.busy, mr.done, mr.err, mr.cnt}) begin
            errors++;
            $display("FAIL status t=%0t act rdy=%0b busy=%0b done=%0b err=%0b cnt=%0d req rdy=%0b busy=%0b done=%0b err=%0b cnt=%0d",
                     $time, io_d_ready, io_busy, io_done, io_err, io_word_cnt, mr.ready, mr.busy, mr.done, mr.err, mr.cnt);
         end
         checks++;
         if (io_configs_out !== mr.img) begin
            errors++;
            for (int i = 0; i < N; i++) begin
               if (io_configs_out[W*i +: W] !== mr.img[W*i +: W]) begin
                  $display("FAIL image t=%0t word %0d act %h req %h", $time, i, io_configs_out[W*i +: W], mr.img[W*i +: W]);
                  break;
               end
            end
         end
         checks++;
         if (io_rd_data !== mr.rd_exp) begin
            errors++;
            $display("FAIL readback t=%0t act %h req %h", $time, io_rd_data, mr.rd_exp);
         end
      end
   end

   initial begin
      bit bad;
      reset = 1'b0; io_start = 1'b0; io_mode = 1'b0; io_addr = '0;
      io_d_in = '0; io_d_valid = 1'b0; io_rd_addr = '0;
      rst_cyc();
      rst_cyc();
      cyc(0, 0, 0, 0, 0);

      // sequential gap-free load; start arrives with valid high
      cyc(1, 1, 0, 0, 32'hFFFF_FFFF);
      seq_words(32'h1000_0000, 0, N, 0);
      cyc(0, 0, 0, 0, 0);

      // same image again with random gaps and ignored starts
      cyc(1, 1, 0, 0, 32'h0BAD_0BAD);
      seq_words(32'h1000_0000, 0, N, 1);
      cyc(0, 0, 0, 0, 0);

      // explicit reverse order
      cyc(1, 0, 0, 0, 0);
      for (int a = N - 1; a >= 0; a--) begin
         if ($urandom_range(0, 3) == 0) cyc(0, 0, 1, a, 0);
         cyc(0, 1, 1, a, ~W'(a));
      end
      cyc(0, 0, 0, 0, 0);

      // out-of-range explicit write mid-session, mixed with sequential words
      cyc(1, 0, 0, 0, 0);
      seq_words(32'h2000_0000, 0, 10, 0);
      cyc(0, 1, 1, 37, 32'hDEAD_BEEF);
      seq_words(32'h2000_0000, 10, N - 10, 1);
      cyc(0, 0, 0, 0, 0);
      bad = 0;
      for (int i = 0; i < N; i++) if (io_configs_out[W*i +: W] == 32'hDEAD_BEEF) bad = 1;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL no_deadbeef act present req absent");
      end

      // reset mid-load with a committed image present, then a clean load
      cyc(1, 0, 0, 0, 0);
      seq_words(32'h3000_0000, 0, 10, 0);
      rst_cyc();
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      seq_words(32'h4000_0000, 0, N, 1);
      cyc(0, 0, 0, 0, 0);

      // double buffering: shadow word 5 changes, active word 5 holds
      cyc(1, 1, 0, 0, 0);
      cyc(0, 1, 1, 5, 32'hA5A5_A5A5);
      force_rd = 5;
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      force_rd = -1;
      seq_words(32'h5000_0000, 0, N - 1, 1);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain act %0d pending req 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/configs_loader.md
Name: configs_loader

Overview:
- Parametrised, clocked successor to the transparent per-word config latches.
- Accepts a stream of WORD_W-bit config words over a valid/ready handshake into a shadow store, either at sequential or explicit word addresses.
- Commits the whole shadow atomically to the active config bus once NUM_WORDS words have been accepted, so the fabric never sees a partially written configuration.
- Sits between the tile config controller and the LUT/routing config bits of a lut_tile.

Parameters:
- WORD_W, 32, width of one config word.
- NUM_WORDS, 37, number of words in the tile config image.
- ADDR_W, $clog2(NUM_WORDS) (min 1), width of word address and counters; derived, not overridden.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- io_start  in  1  pulse; begins a load session from IDLE or DONE.
- io_mode  in  1  0 = sequential addressing, 1 = explicit addressing via io_addr; sampled with each accepted word.
- io_addr  in  ADDR_W  target word index when io_mode=1.
- io_d_in  in  WORD_W  config word.
- io_d_valid  in  1  io_d_in valid.
- io_d_ready  out  1  loader can accept a word this cycle.
- io_busy  out  1  high in LOAD.
- io_done  out  1  high in DONE; active image committed.
- io_err  out  1  sticky out-of-range address flag.
- io_word_cnt  out  ADDR_W+1  words accepted in the current session.
- io_rd_addr  in  ADDR_W  shadow readback index.
- io_rd_data  out  WORD_W  registered shadow readback.
- io_configs_out  out  WORD_W*NUM_WORDS  active config image; word i occupies bits [WORD_W*i +: WORD_W].

Behaviour:
- Reset (reset==0 at a clock edge): the following are all cleared to 0:
  - state = IDLE; shadow and io_configs_out;
  - io_d_ready, io_busy, io_done, io_err;
  - io_word_cnt, seq pointer, io_rd_data.
- Reset asserted mid-LOAD discards the session; the active image is also zeroed.
- States:
  - IDLE: io_d_ready=0. io_start -> LOAD; clear cnt, ptr, io_err.
  - LOAD: io_d_ready=1, io_busy=1. Accept on io_d_valid & io_d_ready.
    - Sequential mode: write shadow[ptr], ptr++.
    - Explicit mode: write shadow[io_addr]; ptr is unchanged.
    - Every in-range accept increments cnt.
    - When the accept makes cnt==NUM_WORDS -> DONE next cycle. That same edge copies the full shadow, including the last word, into io_configs_out.
  - DONE: io_done=1, io_d_ready=0. io_start -> LOAD; clear io_done, cnt, ptr, io_err. The active image holds until the next commit.
- Out of range: explicit io_addr >= NUM_WORDS is accepted (handshake completes). The write is dropped, cnt is not incremented, and io_err is set (sticky until the next io_start or reset).
- Explicit mode rewriting the same index twice counts twice; the last write wins. Completion is purely count-based.
- Mixed modes within a session are legal. The seq ptr only advances on sequential accepts.
- io_start in LOAD is ignored.
- io_start and io_d_valid in the same cycle from IDLE/DONE: no word is accepted that cycle (ready is 0).
- Timing:
  - io_d_ready is a registered function of state, so it has no combinational path from io_d_valid.
  - io_configs_out changes only at the commit edge; there are no transparent latches.
- Readback: io_rd_data = shadow[io_rd_addr], one-cycle latency. Out-of-range io_rd_addr returns 0. Readback is usable in any state.
- Throughput: 1 word/clock in LOAD. A full sequential load takes NUM_WORDS accept cycles, plus 1 cycle for LOAD entry and 1 cycle to DONE.

Decomposition:
- Package configs_pkg holds:
  - the state enum {IDLE, LOAD, DONE};
  - the mode encodings SEQ=0, ADDR=1;
  - helper function cfg_w(WORD_W, NUM_WORDS).
- One sub-module, configs_shadow_ram: NUM_WORDS x WORD_W flop array with a write port and a registered read port. It also exposes the flat shadow vector for commit.
- The FSM, counters and commit logic stay in configs_loader.

Test Plan:
- Sequential load: reset, then start, then stream words 0x1000_0000+i for i=0..36 with valid held high.
  - ready is high in the cycle after start.
  - io_done rises 1 cycle after the 37th accept.
  - io_configs_out[32*i +: 32] == 0x1000_0000+i.
  - io_configs_out stays 0 before the commit edge.
- Backpressure/gaps: random valid gaps during the load.
  - io_word_cnt tracks accepts exactly.
  - The image is identical to the gap-free run.
- Explicit mode, reverse order: io_addr 36..0 with data = ~addr.
  - Commit gives word i == ~i.
  - io_err stays 0.
- Out of range: explicit io_addr=37 with data 0xDEAD_BEEF, mid-session.
  - io_err=1 and io_word_cnt is unchanged.
  - No word in io_configs_out contains 0xDEADBEEF.
  - The next io_start clears io_err.
- Reset mid-load: assert reset low after 10 words of a second session, with a prior committed image present.
  - All outputs are 0 next cycle.
  - A subsequent full load commits correctly.
- Double buffering and readback:
  - After DONE, start a new session and write word 5 = 0xA5A5_A5A5.
  - io_configs_out word 5 keeps its old value.
  - io_rd_addr=5 returns 0xA5A5_A5A5 one cycle later.
